sipo_deser: RTL and testbench

Serial-in/parallel-out deserializer that sits directly downstream of the team's single-bit D flip-flop stage. It consumes that stage's registered serial bit stream `q`, presented here on input `d` with a bit strobe. It assembles WIDTH-bit words and hands each word to the parallel domain through a one-entry valid/ready output register. The serial side never stalls: a word that completes while the output register is still occupied is dropped and flagged.

---
 rtl/sipo_pkg.sv | 12 +
 rtl/sipo_out_reg.sv | 65 ++++++
 rtl/sipo_deser.sv | 69 ++++++
 tb/tb_sipo_deser.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared constants and output-register state encoding for the serial-in/parallel-out deserializer.
package sipo_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned CNT_W        = $clog2(DefaultWidth);

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } out_state_e;

endpackage

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready output register: captures completed words, drops them with a sticky
// overflow flag when the consumer has not drained the previous one.
module sipo_out_reg
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             q_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             ovf
);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StEmpty: begin
                if (load) begin
                    state_d = StFull;
                    data_d  = word;
                end
            end
            StFull: begin
                if (q_ready) begin
                    // Drain and refill on the same edge keeps the register full with no bubble.
                    if (load) begin
                        data_d = word;
                    end else begin
                        state_d = StEmpty;
                    end
                end else if (load) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q       = data_q;
    assign q_valid = (state_q == StFull);
    assign ovf     = ovf_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: shift register and bit counter feeding a one-entry
// valid/ready output register. The serial side never stalls.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     d,
    input  logic                     d_en,
    input  logic                     clr,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     ovf
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             accept;
    logic             word_done;

    always_comb begin
        sr_shift  = MSB_FIRST ? {sr_q[WIDTH-2:0], d} : {d, sr_q[WIDTH-1:1]};
        accept    = d_en && !clr;
        word_done = accept && (cnt_q == CntW'(WIDTH - 1));
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        if (clr || word_done) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (accept) begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

    // The completed word includes the bit arriving on this edge, hence sr_shift, not sr_q.
    sipo_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (word_done),
        .word    (sr_shift),
        .q_ready (q_ready),
        .q       (q),
        .q_valid (q_valid),
        .ovf     (ovf)
    );

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share stimulus and are checked against
// a queue-based model of bit arrival and the output handshake.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b0, d = 1'b0, d_en = 1'b0, clr = 1'b0, q_ready = 1'b0;
    logic [7:0] q_m, q_l;
    logic       qv_m, qv_l, ovf_m, ovf_l;
    logic [2:0] cnt_m, cnt_l;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic       m_bits[$];
    logic       m_valid = 1'b0, m_ovf = 1'b0;
    logic [7:0] m_qm = '0, m_ql = '0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .d(d), .d_en(d_en), .clr(clr),
        .q(q_m), .q_valid(qv_m), .q_ready(q_ready), .cnt(cnt_m), .ovf(ovf_m)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .d(d), .d_en(d_en), .clr(clr),
        .q(q_l), .q_valid(qv_l), .q_ready(q_ready), .cnt(cnt_l), .ovf(ovf_l)
    );

    // Drive one cycle, advance the model, then sample 1 time unit after the edge.
    task automatic step(input logic i_rst, input logic i_d, input logic i_den,
                        input logic i_clr, input logic i_rdy);
        logic       done;
        logic [7:0] wm, wl;
        rst = i_rst; d = i_d; d_en = i_den; clr = i_clr; q_ready = i_rdy;
        done = 1'b0;
        wm = '0;
        wl = '0;
        if (i_rst) begin
            m_bits.delete();
            m_valid = 1'b0; m_ovf = 1'b0; m_qm = '0; m_ql = '0;
        end else begin
            if (i_clr) begin
                m_bits.delete();
            end else if (i_den) begin
                m_bits.push_back(i_d);
                if (m_bits.size() == 8) begin
                    for (int i = 0; i < 8; i++) begin
                        wm[7-i] = m_bits[i];
                        wl[i]   = m_bits[i];
                    end
                    done = 1'b1;
                    m_bits.delete();
                end
            end
            if (m_valid && i_rdy) begin
                if (done) begin m_qm = wm; m_ql = wl; end
                else m_valid = 1'b0;
            end else if (m_valid && done) begin
                m_ovf = 1'b1;
            end else if (!m_valid && done) begin
                m_valid = 1'b1; m_qm = wm; m_ql = wl;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy, input logic rdy_last);
        for (int i = 7; i >= 0; i--) step(1'b0, w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (q_m !== 8'h00) begin n_err++; $display("FAIL reset_q got %h want 00", q_m); end
        n_vec++; if ({qv_m, qv_l} !== 2'b00) begin n_err++; $display("FAIL reset_valid got %b want 00", {qv_m, qv_l}); end
        n_vec++; if (cnt_m !== 3'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", cnt_m); end
        n_vec++; if ({ovf_m, ovf_l} !== 2'b00) begin n_err++; $display("FAIL reset_ovf got %b want 00", {ovf_m, ovf_l}); end
    endtask

    task automatic test_word_order();
        send_word(8'hC0, 1'b1, 1'b1);
        n_vec++; if (q_m !== 8'hC0) begin n_err++; $display("FAIL msb_word got %h want c0", q_m); end
        n_vec++; if (q_l !== 8'h03) begin n_err++; $display("FAIL lsb_word got %h want 03", q_l); end
        n_vec++; if ({qv_m, qv_l} !== 2'b11) begin n_err++; $display("FAIL word_valid got %b want 11", {qv_m, qv_l}); end
        n_vec++; if (cnt_m !== 3'd0) begin n_err++; $display("FAIL word_cnt got %0d want 0", cnt_m); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (qv_m !== 1'b0) begin n_err++; $display("FAIL word_drain got %b want 0", qv_m); end
    endtask

    task automatic test_gapped();
        logic [7:0] w;
        w = 8'hC0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_vec++; if (cnt_l !== 3'(i)) begin n_err++; $display("FAIL gap_cnt got %0d want %0d", cnt_l, i); end
            step(1'b0, w[7-i], 1'b1, 1'b0, 1'b1);
        end
        n_vec++; if (q_l !== 8'h03) begin n_err++; $display("FAIL gap_word got %h want 03", q_l); end
        n_vec++; if (cnt_l !== 3'd0) begin n_err++; $display("FAIL gap_wrap got %0d want 0", cnt_l); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        send_word(8'hC0, 1'b0, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0);
        n_vec++; if (q_m !== 8'hC0) begin n_err++; $display("FAIL ovf_q got %h want c0", q_m); end
        n_vec++; if (q_l !== 8'h03) begin n_err++; $display("FAIL ovf_q_lsb got %h want 03", q_l); end
        n_vec++; if ({qv_m, ovf_m, ovf_l} !== 3'b111) begin n_err++; $display("FAIL ovf_flag got %b want 111", {qv_m, ovf_m, ovf_l}); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++; if ({qv_m, ovf_m} !== 2'b01) begin n_err++; $display("FAIL ovf_sticky got %b want 01", {qv_m, ovf_m}); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'hC0, 1'b0, 1'b0);
        send_word(8'h5A, 1'b0, 1'b1);
        n_vec++; if ({q_m, q_l} !== 16'h5A5A) begin n_err++; $display("FAIL b2b_q got %h want 5a5a", {q_m, q_l}); end
        n_vec++; if ({qv_m, ovf_m} !== 2'b10) begin n_err++; $display("FAIL b2b_flags got %b want 10", {qv_m, ovf_m}); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clr();
        logic [7:0] w;
        w = 8'h5A;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        n_vec++; if ({cnt_m, cnt_l} !== 6'd0) begin n_err++; $display("FAIL clr_cnt got %0d want 0", cnt_m); end
        for (int i = 7; i >= 1; i--) step(1'b0, w[i], 1'b1, 1'b0, 1'b1);
        n_vec++; if (qv_m !== 1'b0) begin n_err++; $display("FAIL clr_spurious got %b want 0", qv_m); end
        step(1'b0, w[0], 1'b1, 1'b0, 1'b1);
        n_vec++; if ({qv_m, q_m} !== 9'h15A) begin n_err++; $display("FAIL clr_word got %h want 15a", {qv_m, q_m}); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        send_word(8'hC0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++; if ({q_m, qv_m, cnt_m, ovf_m} !== 13'd0) begin n_err++; $display("FAIL rstmid_state got %h want 0", {q_m, qv_m, cnt_m, ovf_m}); end
        send_word(8'hA5, 1'b1, 1'b1);
        n_vec++; if ({qv_m, q_m, q_l} !== 17'h1A5A5) begin n_err++; $display("FAIL rstmid_word got %h want 1a5a5", {qv_m, q_m, q_l}); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [21:0] got, exp;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0), 1'($urandom), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0), 1'($urandom));
            got = {q_m, q_l, qv_m, qv_l, cnt_m, ovf_m, ovf_l};
            exp = {m_qm, m_ql, m_valid, m_valid, 3'(m_bits.size()), m_ovf, m_ovf};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random_cycle %0d got %h want %h", n, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_order();
        test_gapped();
        test_overflow();
        test_back_to_back();
        test_clr();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
